// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU definitions used by the MEM/WB stage: datapath widths,
// writeback FSM states and the registered writeback bundle.
package mem_wb_stage_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_REG_AW = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [CPU_DATA_W-1:0] data;
    logic [CPU_REG_AW-1:0] addr;
    logic                  en;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures ALU or load data, drives the register-file
// write port, owns the sticky halt state and the retire/stall performance counters.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              DmemStall,
  input  logic              memToReg,
  input  logic              regWrite_in,
  input  logic [REG_AW-1:0] dst_in,
  input  logic              halt_in,
  input  logic              flush,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_reg,
  output logic              wb_en,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  wb_state_e state_q;
  wb_state_e state_d;
  mem_wb_t   wb_q;
  mem_wb_t   wb_d;
  logic      cap;
  logic      stall_inc;

  // Flush and stall both turn the slot into a bubble; nothing is captured
  // later on its own, the upstream stage decides whether to re-present it.
  assign cap       = valid_in && !DmemStall && !flush && (state_q == RUN);
  assign stall_inc = DmemStall && (state_q == RUN);

  always_comb begin
    state_d = state_q;
    wb_d    = wb_q;
    wb_d.en = 1'b0;
    if (cap) begin
      wb_d.data = memToReg ? mem_out : alu_out;
      wb_d.addr = dst_in;
      wb_d.en   = regWrite_in && !halt_in;
      if (halt_in) begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cap),
    .clear (1'b0),
    .count (retired_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );

  assign wb_data = wb_q.data;
  assign wb_reg  = wb_q.addr;
  assign wb_en   = wb_q.en;
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized scoreboard bench for mem_wb_stage; a narrow-counter copy checks saturation.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] alu_out = '0;
  logic [15:0] mem_out = '0;
  logic        DmemStall = 1'b0;
  logic        memToReg = 1'b0;
  logic        regWrite_in = 1'b0;
  logic [3:0]  dst_in = '0;
  logic        halt_in = 1'b0;
  logic        flush = 1'b0;

  logic [15:0] wb_data;
  logic [3:0]  wb_reg;
  logic        wb_en;
  logic        halted;
  logic [15:0] retired_cnt;
  logic [15:0] stall_cnt;

  logic [15:0] wb_data4;
  logic [3:0]  wb_reg4;
  logic        wb_en4;
  logic        halted4;
  logic [3:0]  retired_cnt4;
  logic [3:0]  stall_cnt4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        en;
    logic [15:0] data;
    logic [3:0]  addr;
    logic        halted;
    int          ret;
    int          stall;
  } exp_t;

  exp_t statusQ[$];

  // Reference model state: what the architecture says has happened so far.
  logic        mHalted;
  int          mRet;
  int          mStall;
  logic [15:0] mData;
  logic [3:0]  mAddr;

  mem_wb_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_out(alu_out), .mem_out(mem_out),
    .DmemStall(DmemStall), .memToReg(memToReg), .regWrite_in(regWrite_in), .dst_in(dst_in),
    .halt_in(halt_in), .flush(flush), .wb_data(wb_data), .wb_reg(wb_reg), .wb_en(wb_en),
    .halted(halted), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  mem_wb_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_out(alu_out), .mem_out(mem_out),
    .DmemStall(DmemStall), .memToReg(memToReg), .regWrite_in(regWrite_in), .dst_in(dst_in),
    .halt_in(halt_in), .flush(flush), .wb_data(wb_data4), .wb_reg(wb_reg4), .wb_en(wb_en4),
    .halted(halted4), .retired_cnt(retired_cnt4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  function automatic int satTo(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    mHalted = 1'b0;
    mRet    = 0;
    mStall  = 0;
    mData   = '0;
    mAddr   = '0;
  endtask

  // Drive one cycle of MEM-stage inputs, then apply the architectural rules at the edge.
  task automatic applyStimulus(input logic v, input logic [15:0] alu, input logic [15:0] mem,
                               input logic st, input logic m2r, input logic rw,
                               input logic [3:0] dst, input logic hlt, input logic fl);
    exp_t e;
    @(negedge clk);
    valid_in = v; alu_out = alu; mem_out = mem; DmemStall = st; memToReg = m2r;
    regWrite_in = rw; dst_in = dst; halt_in = hlt; flush = fl;
    @(posedge clk);
    e.en = 1'b0;
    if (!mHalted) begin
      if (st) mStall++;
      if (v && !st && !fl) begin
        mRet++;
        mData = m2r ? mem : alu;
        mAddr = dst;
        if (hlt) mHalted = 1'b1;
        else e.en = rw;
      end
    end
    e.data = mData; e.addr = mAddr; e.halted = mHalted; e.ret = mRet; e.stall = mStall;
    statusQ.push_back(e);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic aluOp(input logic [15:0] alu, input logic [3:0] dst);
    applyStimulus(1'b1, alu, 16'h0, 1'b0, 1'b0, 1'b1, dst, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wb_en"}, int'(wb_en), 0);
    checkOutput({tag, "_wb_data"}, int'(wb_data), 0);
    checkOutput({tag, "_wb_reg"}, int'(wb_reg), 0);
    checkOutput({tag, "_halted"}, int'(halted), 0);
    checkOutput({tag, "_retired"}, int'(retired_cnt), 0);
    checkOutput({tag, "_stall"}, int'(stall_cnt), 0);
  endtask

  // Monitor: one expected record per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (rst_n && statusQ.size() > 0) begin
      exp_t e;
      e = statusQ.pop_front();
      checkOutput("wb_en", int'(wb_en), int'(e.en));
      checkOutput("wb_data", int'(wb_data), int'(e.data));
      checkOutput("wb_reg", int'(wb_reg), int'(e.addr));
      checkOutput("halted", int'(halted), int'(e.halted));
      checkOutput("retired_cnt", int'(retired_cnt), satTo(e.ret, 16));
      checkOutput("stall_cnt", int'(stall_cnt), satTo(e.stall, 16));
      checkOutput("retired_cnt4", int'(retired_cnt4), satTo(e.ret, 4));
      checkOutput("stall_cnt4", int'(stall_cnt4), satTo(e.stall, 4));
      checkOutput("wb_en4", int'(wb_en4), int'(e.en));
    end
  end

  initial begin
    int drain;
    resetModel();
    #1;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    aluOp(16'h1234, 4'd3);
    idleCycle();

    // Load: two stall cycles with stale data, then the real data on release.
    applyStimulus(1'b1, 16'h0040, 16'hDEAD, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0040, 16'hDEAD, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    idleCycle();
    idleCycle();

    applyStimulus(1'b1, 16'h00FF, 16'h0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h00FF, 16'h0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    idleCycle();

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 9) < 8), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                    4'($urandom), 1'b0, ($urandom_range(0, 9) == 0));
    end
    idleCycle();

    // Async reset in the second stall cycle of a load.
    applyStimulus(1'b1, 16'h0080, 16'hDEAD, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    statusQ.delete();
    resetModel();
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    valid_in = 1'b0; DmemStall = 1'b0; memToReg = 1'b0; regWrite_in = 1'b0; flush = 1'b0;
    rst_n = 1'b1;
    idleCycle();
    idleCycle();

    aluOp(16'hA5A5, 4'd1);
    aluOp(16'h5A5A, 4'd2);
    applyStimulus(1'b1, 16'h0111, 16'h0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
    aluOp(16'h1111, 4'd6);
    applyStimulus(1'b1, 16'h2222, 16'h3333, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
    aluOp(16'h4444, 4'd8);
    idleCycle();

    drain = 0;
    while (statusQ.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    checkOutput("queue_drained", statusQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
